membus_2_arbiter: RTL and testbench

- Shares one memory bus slave port between two masters (m0 = processor, m1 = data channel).
- Grants the bus to one master per complete memory cycle and routes that master's request and data lines to the slave. Routes the slave's responses back to that master only.
- Sits between the masters and a membus connect/memory module. One clock, synchronous logic only.

---
 rtl/membus_2_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_membus_2_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/membus_2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : membus_2_arbiter
//  Purpose  : Two-master arbiter for a single membus slave port. m0 is the
//             processor, m1 the data channel. One master owns the bus for a
//             complete memory cycle (address phase plus data phase).
//  Options  : MEMBUS_ARB_RR_EN - round-robin tie-break instead of fixed
//             priority (m0 > m1).
//  Revision : 1.0 - initial release
// ============================================================================
module membus_2_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 10
) (
    input  logic         clk,
    input  logic         reset,

    // master 0 (processor)
    input  logic         m0_wr_rs,
    input  logic         m0_rq_cyc,
    input  logic         m0_rd_rq,
    input  logic         m0_wr_rq,
    input  logic [21:35] m0_ma,
    input  logic [18:21] m0_sel,
    input  logic         m0_fmc_select,
    input  logic [0:35]  m0_mb_write,
    output logic         m0_addr_ack,
    output logic         m0_rd_rs,
    output logic [0:35]  m0_mb_read,

    // master 1 (data channel)
    input  logic         m1_wr_rs,
    input  logic         m1_rq_cyc,
    input  logic         m1_rd_rq,
    input  logic         m1_wr_rq,
    input  logic [21:35] m1_ma,
    input  logic [18:21] m1_sel,
    input  logic         m1_fmc_select,
    input  logic [0:35]  m1_mb_write,
    output logic         m1_addr_ack,
    output logic         m1_rd_rs,
    output logic [0:35]  m1_mb_read,

    // slave port
    output logic         s_wr_rs,
    output logic         s_rq_cyc,
    output logic         s_rd_rq,
    output logic         s_wr_rq,
    output logic         s_fmc_select,
    output logic [21:35] s_ma,
    output logic [18:21] s_sel,
    output logic [0:35]  s_mb_write,
    input  logic         s_addr_ack,
    input  logic         s_rd_rs,
    input  logic [0:35]  s_mb_read,

    // status
    output logic [1:0]   gnt,
    output logic         nxm
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_WAIT = 2'd1,
        D_WAIT = 2'd2,
        REL    = 2'd3
    } state_t;

    localparam logic [TW-1:0] c_TLAST = TW'(TIMEOUT - 1);

    state_t          state_q;
    logic            own_q;       // 0 = m0 owns, 1 = m1 owns
    logic [1:0]      gnt_q;
    logic            nxm_q;
    logic [TW-1:0]   tcnt_q;
    logic            rq_wr_q;     // cycle was a write (ends on wr_rs rise)
    logic            wr_prev_q;   // routed wr_rs one cycle ago
    logic            rd_prev_q;   // slave rd_rs one cycle ago
`ifdef MEMBUS_ARB_RR_EN
    logic            last_q;      // previous owner, for the round-robin tie-break
`endif

    logic            w_win;       // arbitration winner when in IDLE
    logic            w_act;       // bus currently granted
    logic            w_end;       // data phase complete this cycle

    assign gnt   = gnt_q;
    assign nxm   = nxm_q;
    assign w_act = (gnt_q != 2'b00);

    // Pick the winner among current requesters; a lone requester always wins.
    always_comb begin
        w_win = 1'b0;
`ifdef MEMBUS_ARB_RR_EN
        if (m0_rq_cyc && m1_rq_cyc)
            w_win = ~last_q;
        else
            w_win = ~m0_rq_cyc;
`else
        w_win = ~m0_rq_cyc;
`endif
    end

    // Steer the owner's request lines to the slave and the slave's replies
    // back to the owner only; everything is quiet while nobody holds the bus.
    always_comb begin
        s_wr_rs      = 1'b0;
        s_rq_cyc     = 1'b0;
        s_rd_rq      = 1'b0;
        s_wr_rq      = 1'b0;
        s_fmc_select = 1'b0;
        s_ma         = '0;
        s_sel        = '0;
        s_mb_write   = '0;
        m0_addr_ack  = 1'b0;
        m0_rd_rs     = 1'b0;
        m0_mb_read   = '0;
        m1_addr_ack  = 1'b0;
        m1_rd_rs     = 1'b0;
        m1_mb_read   = '0;
        if (w_act) begin
            if (own_q) begin
                s_wr_rs      = m1_wr_rs;
                s_rq_cyc     = m1_rq_cyc;
                s_rd_rq      = m1_rd_rq;
                s_wr_rq      = m1_wr_rq;
                s_fmc_select = m1_fmc_select;
                s_ma         = m1_ma;
                s_sel        = m1_sel;
                s_mb_write   = m1_mb_write;
                m1_addr_ack  = s_addr_ack;
                m1_rd_rs     = s_rd_rs;
                // the membus data lines are a wired-OR of both drivers
                m1_mb_read   = s_mb_read | m1_mb_write;
            end else begin
                s_wr_rs      = m0_wr_rs;
                s_rq_cyc     = m0_rq_cyc;
                s_rd_rq      = m0_rd_rq;
                s_wr_rq      = m0_wr_rq;
                s_fmc_select = m0_fmc_select;
                s_ma         = m0_ma;
                s_sel        = m0_sel;
                s_mb_write   = m0_mb_write;
                m0_addr_ack  = s_addr_ack;
                m0_rd_rs     = s_rd_rs;
                m0_mb_read   = s_mb_read | m0_mb_write;
            end
        end
    end

    // Write/RMW cycles finish on the owner's wr_rs rising edge, reads on the
    // falling edge of the slave's rd_rs.
    always_comb begin
        w_end = 1'b0;
        if (rq_wr_q)
            w_end = s_wr_rs & ~wr_prev_q;
        else
            w_end = rd_prev_q & ~s_rd_rs;
    end

    // Cycle FSM: grant in IDLE, address phase with timeout, data phase,
    // then one quiet cycle before the next arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            gnt_q     <= 2'b00;
            nxm_q     <= 1'b0;
            tcnt_q    <= '0;
            rq_wr_q   <= 1'b0;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
`ifdef MEMBUS_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            nxm_q     <= 1'b0;
            wr_prev_q <= s_wr_rs;
            rd_prev_q <= s_rd_rs;
            case (state_q)
                IDLE: begin
                    if (m0_rq_cyc || m1_rq_cyc) begin
                        own_q   <= w_win;
                        gnt_q   <= w_win ? 2'b10 : 2'b01;
                        tcnt_q  <= '0;
                        state_q <= A_WAIT;
`ifdef MEMBUS_ARB_RR_EN
                        last_q  <= w_win;
`endif
                    end
                end
                A_WAIT: begin
                    tcnt_q <= tcnt_q + TW'(1);
                    if (s_addr_ack) begin
                        rq_wr_q <= s_wr_rq;
                        state_q <= D_WAIT;
                    end else if (!s_rq_cyc) begin
                        // owner withdrew before the address was accepted
                        gnt_q   <= 2'b00;
                        state_q <= REL;
                    end else if (tcnt_q == c_TLAST) begin
                        // nonexistent memory: nxm is high during the quiet cycle
                        nxm_q   <= 1'b1;
                        gnt_q   <= 2'b00;
                        state_q <= REL;
                    end
                end
                D_WAIT: begin
                    if (w_end) begin
                        gnt_q   <= 2'b00;
                        state_q <= REL;
                    end
                end
                REL: begin
                    state_q <= IDLE;
                end
                default: begin
                    gnt_q   <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_membus_2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_membus_2_arbiter
//  Purpose  : Directed self-checking bench for membus_2_arbiter
//             (TIMEOUT=8, TW=4). Tie expectations follow MEMBUS_ARB_RR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_membus_2_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         m0_wr_rs, m0_rq_cyc, m0_rd_rq, m0_wr_rq, m0_fmc_select;
    logic [21:35] m0_ma;
    logic [18:21] m0_sel;
    logic [0:35]  m0_mb_write;
    logic         m0_addr_ack, m0_rd_rs;
    logic [0:35]  m0_mb_read;
    logic         m1_wr_rs, m1_rq_cyc, m1_rd_rq, m1_wr_rq, m1_fmc_select;
    logic [21:35] m1_ma;
    logic [18:21] m1_sel;
    logic [0:35]  m1_mb_write;
    logic         m1_addr_ack, m1_rd_rs;
    logic [0:35]  m1_mb_read;
    logic         s_wr_rs, s_rq_cyc, s_rd_rq, s_wr_rq, s_fmc_select;
    logic [21:35] s_ma;
    logic [18:21] s_sel;
    logic [0:35]  s_mb_write;
    logic         s_addr_ack, s_rd_rs;
    logic [0:35]  s_mb_read;
    logic [1:0]   gnt;
    logic         nxm;

    int vecs = 0;
    int miss = 0;

    membus_2_arbiter #(.TIMEOUT(8), .TW(4)) dut (
        .clk(clk), .reset(reset),
        .m0_wr_rs(m0_wr_rs), .m0_rq_cyc(m0_rq_cyc), .m0_rd_rq(m0_rd_rq),
        .m0_wr_rq(m0_wr_rq), .m0_ma(m0_ma), .m0_sel(m0_sel),
        .m0_fmc_select(m0_fmc_select), .m0_mb_write(m0_mb_write),
        .m0_addr_ack(m0_addr_ack), .m0_rd_rs(m0_rd_rs), .m0_mb_read(m0_mb_read),
        .m1_wr_rs(m1_wr_rs), .m1_rq_cyc(m1_rq_cyc), .m1_rd_rq(m1_rd_rq),
        .m1_wr_rq(m1_wr_rq), .m1_ma(m1_ma), .m1_sel(m1_sel),
        .m1_fmc_select(m1_fmc_select), .m1_mb_write(m1_mb_write),
        .m1_addr_ack(m1_addr_ack), .m1_rd_rs(m1_rd_rs), .m1_mb_read(m1_mb_read),
        .s_wr_rs(s_wr_rs), .s_rq_cyc(s_rq_cyc), .s_rd_rq(s_rd_rq),
        .s_wr_rq(s_wr_rq), .s_fmc_select(s_fmc_select), .s_ma(s_ma),
        .s_sel(s_sel), .s_mb_write(s_mb_write), .s_addr_ack(s_addr_ack),
        .s_rd_rs(s_rd_rs), .s_mb_read(s_mb_read), .gnt(gnt), .nxm(nxm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // from an address-wait cycle: ack, one rd_rs pulse, land in the quiet cycle
    task automatic finish_read();
        s_addr_ack = 1'b1; tick();
        s_addr_ack = 1'b0; s_rd_rs = 1'b1; tick();
        s_rd_rs = 1'b0; tick();
    endtask

    initial begin
        reset = 1'b1;
        m0_wr_rs = 0; m0_rq_cyc = 0; m0_rd_rq = 0; m0_wr_rq = 0; m0_fmc_select = 0;
        m0_ma = '0; m0_sel = '0; m0_mb_write = '0;
        m1_wr_rs = 0; m1_rq_cyc = 0; m1_rd_rq = 0; m1_wr_rq = 0; m1_fmc_select = 0;
        m1_ma = '0; m1_sel = '0; m1_mb_write = '0;
        s_addr_ack = 0; s_rd_rs = 0; s_mb_read = '0;

        // ---- reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_nxm", 64'(nxm), 64'd0);
        chk("rst_s_rq_cyc", 64'(s_rq_cyc), 64'd0);

        // ---- read by m0
        m0_rq_cyc = 1; m0_rd_rq = 1; m0_ma = 15'o12345; m0_sel = 4'h3;
        #1;
        chk("rd_pre_gnt", 64'(gnt), 64'd0);
        chk("rd_pre_s_rq", 64'(s_rq_cyc), 64'd0);
        tick();
        chk("rd_gnt", 64'(gnt), 64'd1);
        chk("rd_s_rq_cyc", 64'(s_rq_cyc), 64'd1);
        chk("rd_s_ma", 64'(s_ma), 64'o12345);
        chk("rd_s_sel", 64'(s_sel), 64'h3);
        chk("rd_s_rd_rq", 64'(s_rd_rq), 64'd1);
        tick(); tick();
        s_addr_ack = 1; #1;
        chk("rd_m0_ack", 64'(m0_addr_ack), 64'd1);
        chk("rd_m1_ack", 64'(m1_addr_ack), 64'd0);
        tick();
        s_addr_ack = 0; s_rd_rs = 1; s_mb_read = 36'o123456654321; #1;
        chk("rd_m0_data", 64'(m0_mb_read), 64'o123456654321);
        chk("rd_m0_rd_rs", 64'(m0_rd_rs), 64'd1);
        chk("rd_m1_data", 64'(m1_mb_read), 64'd0);
        chk("rd_m1_rd_rs", 64'(m1_rd_rs), 64'd0);
        tick();
        s_rd_rs = 0; s_mb_read = '0; m0_rq_cyc = 0; m0_rd_rq = 0; #1;
        chk("rd_hold_gnt", 64'(gnt), 64'd1);
        tick();
        chk("rd_rel_gnt", 64'(gnt), 64'd0);
        chk("rd_rel_s_ma", 64'(s_ma), 64'd0);
        tick();
        chk("rd_idle_gnt", 64'(gnt), 64'd0);

        // ---- write by m1
        m1_rq_cyc = 1; m1_wr_rq = 1; m1_mb_write = 36'o777000777000; m1_ma = 15'o00777;
        tick();
        chk("wr_gnt", 64'(gnt), 64'd2);
        chk("wr_s_data", 64'(s_mb_write), 64'o777000777000);
        chk("wr_s_wr_rq", 64'(s_wr_rq), 64'd1);
        chk("wr_s_ma", 64'(s_ma), 64'o00777);
        s_addr_ack = 1; #1;
        chk("wr_m0_ack", 64'(m0_addr_ack), 64'd0);
        chk("wr_m1_ack", 64'(m1_addr_ack), 64'd1);
        tick();
        s_addr_ack = 0; #1;
        chk("wr_m1_wiredor", 64'(m1_mb_read), 64'o777000777000);
        tick();
        chk("wr_wait_gnt", 64'(gnt), 64'd2);
        m1_wr_rs = 1; #1;
        chk("wr_s_wr_rs", 64'(s_wr_rs), 64'd1);
        tick();
        chk("wr_rel_gnt", 64'(gnt), 64'd0);
        m1_wr_rs = 0; m1_rq_cyc = 0; m1_wr_rq = 0; m1_mb_write = '0;
        tick();
        chk("wr_idle_gnt", 64'(gnt), 64'd0);

        // ---- simultaneous requests, both keep requesting
        m0_rq_cyc = 1; m0_rd_rq = 1; m0_ma = 15'o00100;
        m1_rq_cyc = 1; m1_rd_rq = 1; m1_ma = 15'o04321; m1_sel = 4'hA;
        tick();
        chk("tie_gnt1", 64'(gnt), 64'd1);
        finish_read();
        chk("tie_rel1", 64'(gnt), 64'd0);
        tick(); tick();
`ifdef MEMBUS_ARB_RR_EN
        chk("tie_gnt2", 64'(gnt), 64'd2);
`else
        chk("tie_gnt2", 64'(gnt), 64'd1);
`endif
        finish_read();
        chk("tie_rel2", 64'(gnt), 64'd0);
        tick(); tick();
        chk("tie_gnt3", 64'(gnt), 64'd1);

        // ---- timeout on the third grant (m0), m1 still pending
        repeat (7) tick();
        chk("to_a8_gnt", 64'(gnt), 64'd1);
        chk("to_a8_nxm", 64'(nxm), 64'd0);
        tick();
        chk("to_rel_gnt", 64'(gnt), 64'd0);
        chk("to_rel_nxm", 64'(nxm), 64'd1);
        m0_rq_cyc = 0; m0_rd_rq = 0;
        tick();
        chk("to_idle_nxm", 64'(nxm), 64'd0);
        chk("to_idle_gnt", 64'(gnt), 64'd0);
        tick();
        chk("to_m1_gnt", 64'(gnt), 64'd2);
        chk("to_m1_s_ma", 64'(s_ma), 64'o04321);
        chk("to_m1_s_sel", 64'(s_sel), 64'hA);
        finish_read();
        m1_rq_cyc = 0; m1_rd_rq = 0;
        tick();

        // ---- contention: m1 asks while m0 is in its data phase
        m0_rq_cyc = 1; m0_rd_rq = 1;
        tick();
        chk("ct_m0_gnt", 64'(gnt), 64'd1);
        s_addr_ack = 1; tick();
        m1_rq_cyc = 1; m1_rd_rq = 1; m1_ma = 15'o07070; m1_sel = 4'h5;
        s_rd_rs = 1; s_mb_read = 36'o1; #1;
        chk("ct_m1_ack", 64'(m1_addr_ack), 64'd0);
        chk("ct_m1_rd_rs", 64'(m1_rd_rs), 64'd0);
        chk("ct_m1_data", 64'(m1_mb_read), 64'd0);
        chk("ct_m0_rd_rs", 64'(m0_rd_rs), 64'd1);
        chk("ct_s_ma", 64'(s_ma), 64'o00100);
        tick();
        s_rd_rs = 0; s_addr_ack = 0; s_mb_read = '0; m0_rq_cyc = 0; m0_rd_rq = 0;
        tick();
        chk("ct_rel_gnt", 64'(gnt), 64'd0);
        tick();
        chk("ct_idle_gnt", 64'(gnt), 64'd0);
        tick();
        chk("ct_m1_gnt", 64'(gnt), 64'd2);
        chk("ct_m1_s_ma", 64'(s_ma), 64'o07070);
        chk("ct_m1_s_sel", 64'(s_sel), 64'h5);

        // ---- reset during the data phase
        s_addr_ack = 1; tick();
        reset = 1; tick();
        chk("rs_gnt", 64'(gnt), 64'd0);
        chk("rs_nxm", 64'(nxm), 64'd0);
        chk("rs_s_rq_cyc", 64'(s_rq_cyc), 64'd0);
        chk("rs_s_rd_rq", 64'(s_rd_rq), 64'd0);
        chk("rs_s_ma", 64'(s_ma), 64'd0);
        chk("rs_m1_ack", 64'(m1_addr_ack), 64'd0);
        reset = 0; s_addr_ack = 0; m1_rq_cyc = 0; m1_rd_rq = 0;
        tick();
        m0_rq_cyc = 1; m0_rd_rq = 1;
        tick();
        chk("rs_new_gnt", 64'(gnt), 64'd1);
        chk("rs_new_s_rq", 64'(s_rq_cyc), 64'd1);
        finish_read();
        chk("rs_new_rel", 64'(gnt), 64'd0);
        m0_rq_cyc = 0; m0_rd_rq = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
`default_nettype wire
